instruction_cache: RTL and testbench

Direct-mapped, read-only instruction cache between the CPU fetch port and `instruction_memory`. Serves 32-bit instructions on a hit in the same cycle. Refills whole 128-bit blocks from memory on a miss, holding the CPU with a busywait. The CPU fetch stage is its only client; the memory side follows the existing block-read handshake (28-bit block address, 128-bit data, busywait).

---
 rtl/instruction_cache_pkg.sv | 24 ++
 rtl/instruction_cache_storage.sv | 53 +++++
 rtl/instruction_cache.sv | 132 +++++++++++++
 tb/tb_instruction_cache.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/instruction_cache_pkg.sv
// ============================================================================
// Module      : instruction_cache_pkg
// Description : Shared widths and FSM state encoding for the instruction cache
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package instruction_cache_pkg;

  localparam int BLOCK_W       = 128;
  localparam int WORD_W        = 32;
  localparam int BLOCK_ADDR_W  = 28;
  localparam int OFFSET_W      = 2;   // word select within a block
  localparam int BYTE_OFFSET_W = 4;   // byte address bits below the block address

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/instruction_cache_storage.sv
// ============================================================================
// Module      : instruction_cache_storage
// Description : Valid/tag/data arrays, asynchronous read, synchronous fill
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_cache_storage
  import instruction_cache_pkg::*;
#(
  parameter int LINES   = 8,
  parameter int INDEX_W = 3,
  parameter int TAG_W   = 25
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INDEX_W-1:0] i_rd_index,
  output logic               o_rd_valid,
  output logic [TAG_W-1:0]   o_rd_tag,
  output logic [BLOCK_W-1:0] o_rd_data,
  input  logic               i_wr_en,
  input  logic [INDEX_W-1:0] i_wr_index,
  input  logic [TAG_W-1:0]   i_wr_tag,
  input  logic [BLOCK_W-1:0] i_wr_data
);

  logic [LINES-1:0]   r_valid;
  logic [TAG_W-1:0]   r_tag  [LINES];
  logic [BLOCK_W-1:0] r_data [LINES];

  // Only the valid bits are cleared; tag/data are don't-care until a fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tag[i_wr_index]  <= i_wr_tag;
      r_data[i_wr_index] <= i_wr_data;
    end
  end

  assign o_rd_valid = r_valid[i_rd_index];
  assign o_rd_tag   = r_tag[i_rd_index];
  assign o_rd_data  = r_data[i_rd_index];

endmodule

`default_nettype wire

// File: rtl/instruction_cache.sv
// ============================================================================
// Module      : instruction_cache
// Description : Direct-mapped read-only instruction cache with block refill
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_cache
  import instruction_cache_pkg::*;
#(
  parameter int LINES = 8
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    READ,
  input  logic [31:0]             ADDRESS,
  output logic [WORD_W-1:0]       INSTRUCTION,
  output logic                    BUSYWAIT,
  output logic                    MEM_READ,
  output logic [BLOCK_ADDR_W-1:0] MEM_ADDRESS,
  input  logic [BLOCK_W-1:0]      MEM_READDATA,
  input  logic                    MEM_BUSYWAIT
);

  localparam int INDEX_W = $clog2(LINES);
  localparam int TAG_W   = BLOCK_ADDR_W - INDEX_W;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [BLOCK_ADDR_W-1:0] r_blk_addr;

  logic [INDEX_W-1:0]      w_index;
  logic [TAG_W-1:0]        w_tag;
  logic [OFFSET_W-1:0]     w_offset;
  logic                    w_rd_valid;
  logic [TAG_W-1:0]        w_rd_tag;
  logic [BLOCK_W-1:0]      w_rd_data;
  logic                    w_hit;
  logic [WORD_W-1:0]       w_word;
  logic                    w_fill;
  logic                    w_busywait;
  logic                    w_mem_read;
  logic [WORD_W-1:0]       w_instruction;
  logic                    w_unused_byte_bits;

  assign w_index            = ADDRESS[BYTE_OFFSET_W +: INDEX_W];
  assign w_tag              = ADDRESS[31 -: TAG_W];
  assign w_offset           = ADDRESS[BYTE_OFFSET_W-1:2];
  assign w_unused_byte_bits = ^ADDRESS[1:0];

  instruction_cache_storage #(
    .LINES   (LINES),
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_storage (
    .clk        (CLK),
    .rst_n      (RESET),
    .i_rd_index (w_index),
    .o_rd_valid (w_rd_valid),
    .o_rd_tag   (w_rd_tag),
    .o_rd_data  (w_rd_data),
    .i_wr_en    (w_fill),
    .i_wr_index (r_blk_addr[INDEX_W-1:0]),
    .i_wr_tag   (r_blk_addr[BLOCK_ADDR_W-1 -: TAG_W]),
    .i_wr_data  (MEM_READDATA)
  );

  assign w_hit  = READ & w_rd_valid & (w_rd_tag == w_tag);
  assign w_word = w_rd_data[{w_offset, 5'b0} +: WORD_W];

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // The refill runs only from this latched copy, so ADDRESS may wander.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_blk_addr <= '0;
    end else if (r_state == IDLE && READ && !w_hit) begin
      r_blk_addr <= ADDRESS[31:BYTE_OFFSET_W];
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_busywait    = 1'b0;
    w_mem_read    = 1'b0;
    w_fill        = 1'b0;
    w_instruction = '0;
    // Gating on RESET keeps every output quiet while reset is held.
    if (RESET) begin
      case (r_state)
        IDLE: begin
          if (w_hit) begin
            w_instruction = w_word;
          end else if (READ) begin
            w_busywait   = 1'b1;
            w_next_state = MEM_REQ;
          end
        end
        MEM_REQ: begin
          w_mem_read = 1'b1;
          w_busywait = 1'b1;
          if (MEM_BUSYWAIT) begin
            w_next_state = MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          w_mem_read = 1'b1;
          w_busywait = 1'b1;
          if (!MEM_BUSYWAIT) begin
            w_fill       = 1'b1;
            w_next_state = IDLE;
          end
        end
        default: w_next_state = IDLE;
      endcase
    end
  end

  assign INSTRUCTION = w_instruction;
  assign BUSYWAIT    = w_busywait;
  assign MEM_READ    = w_mem_read;
  assign MEM_ADDRESS = w_mem_read ? r_blk_addr : '0;

endmodule

`default_nettype wire

// File: tb/tb_instruction_cache.sv
// ============================================================================
// Module      : tb_instruction_cache
// Description : Self-checking bench for instruction_cache with memory model
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_cache;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         READ;
  logic [31:0]  ADDRESS;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic [27:0]  MEM_ADDRESS;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;

  int n_checks = 0;
  int n_errors = 0;

  instruction_cache #(.LINES(8)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .READ         (READ),
    .ADDRESS      (ADDRESS),
    .INSTRUCTION  (INSTRUCTION),
    .BUSYWAIT     (BUSYWAIT),
    .MEM_READ     (MEM_READ),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .MEM_READDATA (MEM_READDATA),
    .MEM_BUSYWAIT (MEM_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  // Memory content: each word is a unique function of its block and word number.
  function automatic logic [31:0] mem_word(input logic [27:0] blk, input int k);
    return ({blk, 4'b0} + 32'(k)) ^ 32'hC0DE_0000;
  endfunction

  // Instruction memory: busy for mem_lat cycles once a read appears, then
  // presents data with busywait low for one cycle.
  int mem_lat = 1;
  int mem_cnt;
  assign MEM_BUSYWAIT = MEM_READ && (mem_cnt < mem_lat);
  assign MEM_READDATA = {mem_word(MEM_ADDRESS, 3), mem_word(MEM_ADDRESS, 2),
                         mem_word(MEM_ADDRESS, 1), mem_word(MEM_ADDRESS, 0)};

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) mem_cnt <= 0;
    else if (!MEM_READ) mem_cnt <= 0;
    else if (mem_cnt < mem_lat) mem_cnt <= mem_cnt + 1;
  end

  // Reference model: which block each of the 8 lines currently holds.
  bit          m_valid [8];
  logic [24:0] m_tag   [8];

  function automatic bit model_hit(input logic [31:0] a);
    return m_valid[a[6:4]] && (m_tag[a[6:4]] == a[31:7]);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (addr %h, t=%0t)", name, act, exp, ADDRESS, $time);
    end
  endtask

  // One CPU fetch, held until BUSYWAIT drops or the cycle budget expires.
  task automatic fetch(input logic [31:0] a, input int lat, input bit exp_hit,
                       input logic [27:0] exp_maddr);
    int  busy;
    bit  first;
    @(posedge CLK);
    #1;
    READ    = 1'b1;
    ADDRESS = a;
    mem_lat = lat;
    @(negedge CLK);
    check("hit_busywait", {31'b0, BUSYWAIT}, {31'b0, !exp_hit});
    if (!exp_hit) begin
      check("idle_mem_read", {31'b0, MEM_READ}, 32'd0);
      busy  = 1;
      first = 1'b1;
      for (int i = 0; i < 60 && BUSYWAIT; i++) begin
        @(negedge CLK);
        if (BUSYWAIT) begin
          busy++;
          if (first) begin
            check("req_mem_read", {31'b0, MEM_READ}, 32'd1);
            check("mem_address", {4'b0, MEM_ADDRESS}, {4'b0, exp_maddr});
            first = 1'b0;
          end
        end
      end
      check("busy_cycles", busy, lat + 2);
      m_valid[a[6:4]] = 1'b1;
      m_tag[a[6:4]]   = a[31:7];
    end
    check("instruction", INSTRUCTION, mem_word(a[31:4], int'(a[3:2])));
    check("mem_read_idle", {31'b0, MEM_READ}, 32'd0);
  endtask

  typedef struct {
    logic [31:0] addr;
    int          lat;
    bit          hit;
    logic [27:0] maddr;
  } vec_t;

  vec_t tbl [$];

  initial begin
    logic [31:0] ra;
    tbl.push_back('{32'h0000_0000, 2, 1'b0, 28'h000_0000});
    tbl.push_back('{32'h0000_0004, 1, 1'b1, 28'h000_0000});
    tbl.push_back('{32'h0000_0008, 1, 1'b1, 28'h000_0000});
    tbl.push_back('{32'h0000_000C, 1, 1'b1, 28'h000_0000});
    tbl.push_back('{32'h0000_0080, 3, 1'b0, 28'h000_0008});
    tbl.push_back('{32'h0000_0000, 1, 1'b0, 28'h000_0000});
    tbl.push_back('{32'h0000_0010, 2, 1'b0, 28'h000_0001});
    tbl.push_back('{32'h0000_0020, 2, 1'b0, 28'h000_0002});
    tbl.push_back('{32'h0000_0017, 1, 1'b1, 28'h000_0000});
    tbl.push_back('{32'h0000_0030, 5, 1'b0, 28'h000_0003});

    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;

    // Reset with a pending fetch: outputs must stay quiet.
    RESET   = 1'b0;
    READ    = 1'b1;
    ADDRESS = 32'h0;
    repeat (2) @(negedge CLK);
    check("rst_busywait", {31'b0, BUSYWAIT}, 32'd0);
    check("rst_mem_read", {31'b0, MEM_READ}, 32'd0);
    check("rst_mem_address", {4'b0, MEM_ADDRESS}, 32'd0);
    check("rst_instruction", INSTRUCTION, 32'd0);
    READ  = 1'b0;
    RESET = 1'b1;
    @(negedge CLK);
    check("noread_busywait", {31'b0, BUSYWAIT}, 32'd0);

    foreach (tbl[i]) fetch(tbl[i].addr, tbl[i].lat, tbl[i].hit, tbl[i].maddr);

    // Reset during MEM_WAIT abandons the refill.
    @(posedge CLK);
    #1;
    READ    = 1'b1;
    ADDRESS = 32'h0000_0040;
    mem_lat = 4;
    repeat (3) @(negedge CLK);
    check("pre_rst_mem_read", {31'b0, MEM_READ}, 32'd1);
    #2 RESET = 1'b0;
    #1;
    check("midrst_mem_read", {31'b0, MEM_READ}, 32'd0);
    check("midrst_busywait", {31'b0, BUSYWAIT}, 32'd0);
    check("midrst_mem_address", {4'b0, MEM_ADDRESS}, 32'd0);
    READ = 1'b0;
    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    fetch(32'h0000_0040, 2, 1'b0, 28'h000_0004);
    fetch(32'h0000_0000, 1, 1'b0, 28'h000_0000);

    // Random fetches over a small address pool so hits and evictions mix.
    for (int n = 0; n < 40; n++) begin
      ra = (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 7)) << 4) |
           32'($urandom_range(0, 15));
      fetch(ra, int'($urandom_range(1, 4)), model_hit(ra), ra[31:4]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
